// File: rtl/dmni_ni_mc.sv
// dmni_ni_mc: multi-channel NI configuration block.
// CPU memory-mapped front end for N banked Hermes DMA channels and a queued
// BrLite transmit path. Adds an IRQ mask, sticky write-1-to-clear status bits,
// a BR_TX_DEPTH-deep TX FIFO and a request FSM toward the BrLite engine.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   irq_o                          registered |(IRQ_STATUS & IRQ_MASK)
//   cfg_en_i/cfg_we_i/cfg_addr_i   MMR strobe, write enable, word address
//   cfg_data_i/cfg_data_o          write data / registered read data
//   hermes_active_i                per-channel engine busy
//   hermes_rx_available_i          per-channel receive pending
//   hermes_flits_available_i       per-channel flits available (N*FLIT)
//   hermes_start_o                 one-cycle start pulse per channel
//   hermes_operation_o             hermes_op_t per channel
//   hermes_size_o/_size_2_o        per-channel sizes (N*32)
//   hermes_address_o/_address_2_o  per-channel addresses (N*32)
//   br_svc_rx_i/br_svc_ack_o       service FIFO not-empty / one-cycle pop
//   br_svc_data_i                  head service entry
//   br_local_busy_i                BrLite local port busy
//   br_req_o/br_ack_i/br_data_o    BrLite send handshake and payload
//
// Optional feature macro: DMNI_BR_WDT_EN enables the BrLite ack watchdog
// (BR_WDT_CYCLES). Without it a request waits for ack indefinitely.

package dmni_ni_mc_pkg;
  localparam int unsigned HERMES_OP_W = 1;

  typedef enum logic [HERMES_OP_W-1:0] {
    HERMES_OPERATION_SEND    = 1'b0,
    HERMES_OPERATION_RECEIVE = 1'b1
  } hermes_op_t;

  typedef struct packed {
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;

  typedef struct packed {
    logic [1:0]  service;
    logic [7:0]  ksvc;
    logic [15:0] target;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_out_t;
endpackage

module dmni_ni_mc
  import dmni_ni_mc_pkg::*;
#(
  parameter int unsigned HERMES_FLIT_SIZE = 32,
  parameter int unsigned N_HERMES_CH      = 2,
  parameter int unsigned BR_TX_DEPTH      = 4,
  parameter int unsigned BR_WDT_CYCLES    = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  output logic                                   irq_o,
  input  logic                                   cfg_en_i,
  input  logic                                   cfg_we_i,
  input  logic [5:0]                             cfg_addr_i,
  input  logic [31:0]                            cfg_data_i,
  output logic [31:0]                            cfg_data_o,
  input  logic [N_HERMES_CH-1:0]                 hermes_active_i,
  input  logic [N_HERMES_CH-1:0]                 hermes_rx_available_i,
  input  logic [N_HERMES_CH*HERMES_FLIT_SIZE-1:0] hermes_flits_available_i,
  output logic [N_HERMES_CH-1:0]                 hermes_start_o,
  output logic [N_HERMES_CH*HERMES_OP_W-1:0]     hermes_operation_o,
  output logic [N_HERMES_CH*32-1:0]              hermes_size_o,
  output logic [N_HERMES_CH*32-1:0]              hermes_size_2_o,
  output logic [N_HERMES_CH*32-1:0]              hermes_address_o,
  output logic [N_HERMES_CH*32-1:0]              hermes_address_2_o,
  input  logic                                   br_svc_rx_i,
  output logic                                   br_svc_ack_o,
  input  brlite_svc_t                            br_svc_data_i,
  input  logic                                   br_local_busy_i,
  output logic                                   br_req_o,
  input  logic                                   br_ack_i,
  output brlite_out_t                            br_data_o
);

  localparam int unsigned SEL_W = (N_HERMES_CH > 1) ? $clog2(N_HERMES_CH) : 1;
  localparam int unsigned PTR_W = $clog2(BR_TX_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [5:0] A_STATUS     = 6'h00, A_IRQ_STATUS = 6'h01, A_IRQ_MASK   = 6'h02;
  localparam logic [5:0] A_IRQ_CLEAR  = 6'h03, A_PENDING    = 6'h04, A_CH_SEL     = 6'h08;
  localparam logic [5:0] A_START      = 6'h09, A_OP         = 6'h0A, A_SIZE       = 6'h0B;
  localparam logic [5:0] A_SIZE2      = 6'h0C, A_ADDR       = 6'h0D, A_ADDR2      = 6'h0E;
  localparam logic [5:0] A_FLITS      = 6'h0F, A_SERVICE    = 6'h10, A_KSVC       = 6'h11;
  localparam logic [5:0] A_TARGET     = 6'h12, A_PRODUCER   = 6'h13, A_PAYLOAD    = 6'h14;
  localparam logic [5:0] A_BR_PUSH    = 6'h15, A_TX_COUNT   = 6'h16, A_SVC_KSVC   = 6'h18;
  localparam logic [5:0] A_SVC_PROD   = 6'h19, A_SVC_PAY    = 6'h1A, A_SVC_POP    = 6'h1B;

  typedef enum logic {S_IDLE, S_REQ} tx_state_t;

  // Elaboration-time guard on the legal parameter space
  if (N_HERMES_CH < 1 || N_HERMES_CH > 8 || HERMES_FLIT_SIZE < 1 || HERMES_FLIT_SIZE > 32 ||
      BR_TX_DEPTH < 2 || (BR_TX_DEPTH & (BR_TX_DEPTH - 1)) != 0 || BR_WDT_CYCLES < 1)
  begin : g_param_check
    $error("dmni_ni_mc: illegal parameter set");
  end

  // Configuration state
  logic [SEL_W-1:0] sel_q;
  hermes_op_t       op_q    [N_HERMES_CH];
  logic [31:0]      size_q  [N_HERMES_CH];
  logic [31:0]      size2_q [N_HERMES_CH];
  logic [31:0]      addr_q  [N_HERMES_CH];
  logic [31:0]      addr2_q [N_HERMES_CH];
  logic [6:0]       mask_q;
  logic             pending_q;
  logic             tx_done_q, tx_ovf_q, start_err_q, tx_to_q;
  brlite_out_t      stage_q;

  // TX FIFO and FSM state
  brlite_out_t      mem_q [BR_TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  tx_state_t        state_q;

  logic        wr_c, rd_c, push_req_c, push_ok_c, pop_c, start_req_c, svc_pop_c;
  logic        fifo_full_c, fifo_empty_c, wdt_expire_c;
  logic        done_evt_c, ovf_evt_c, start_err_evt_c, timeout_evt_c;
  logic [6:0]  clr_c, irq_status_c;
  logic [31:0] rdata_c;
  hermes_op_t  sel_op_c;
  logic [31:0] sel_size_c, sel_size2_c, sel_addr_c, sel_addr2_c, sel_flits_c;
  logic        sel_active_c;

  assign wr_c = cfg_en_i & cfg_we_i;
  assign rd_c = cfg_en_i & ~cfg_we_i;

  assign fifo_full_c  = (cnt_q == CNT_W'(BR_TX_DEPTH));
  assign fifo_empty_c = (cnt_q == '0);

  assign push_req_c  = wr_c && (cfg_addr_i == A_BR_PUSH) && cfg_data_i[0];
  assign start_req_c = wr_c && (cfg_addr_i == A_START) && cfg_data_i[0];
  assign svc_pop_c   = wr_c && (cfg_addr_i == A_SVC_POP) && cfg_data_i[0];
  assign clr_c       = (wr_c && cfg_addr_i == A_IRQ_CLEAR) ? {cfg_data_i[6:3], 3'b000} : 7'd0;

  // Ack has priority over watchdog expiry in the same cycle
  assign pop_c         = (state_q == S_REQ) && (br_ack_i || wdt_expire_c);
  assign done_evt_c    = (state_q == S_REQ) && br_ack_i;
  assign timeout_evt_c = (state_q == S_REQ) && !br_ack_i && wdt_expire_c;

  // A full FIFO still accepts a push when an entry leaves in the same cycle
  assign push_ok_c       = push_req_c && (!fifo_full_c || pop_c);
  assign ovf_evt_c       = push_req_c && !push_ok_c;
  assign start_err_evt_c = start_req_c && sel_active_c;

  assign irq_status_c = {tx_to_q, start_err_q, tx_ovf_q, tx_done_q, pending_q,
                         br_svc_rx_i, |hermes_rx_available_i};

`ifdef DMNI_BR_WDT_EN
  localparam int unsigned WDT_W = $clog2(BR_WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_q;

  // Cycles spent in REQ; zero on the first request cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 wdt_q <= '0;
    else if (state_q != S_REQ) wdt_q <= '0;
    else                       wdt_q <= wdt_q + WDT_W'(1);
  end

  assign wdt_expire_c = (state_q == S_REQ) && (wdt_q == WDT_W'(BR_WDT_CYCLES - 1));
`else
  assign wdt_expire_c = 1'b0;
`endif

  // Selected-channel view for reads and start checks
  always_comb begin
    sel_op_c     = HERMES_OPERATION_SEND;
    sel_size_c   = '0;
    sel_size2_c  = '0;
    sel_addr_c   = '0;
    sel_addr2_c  = '0;
    sel_flits_c  = '0;
    sel_active_c = 1'b0;
    for (int c = 0; c < int'(N_HERMES_CH); c++) begin
      if (sel_q == SEL_W'(c)) begin
        sel_op_c     = op_q[c];
        sel_size_c   = size_q[c];
        sel_size2_c  = size2_q[c];
        sel_addr_c   = addr_q[c];
        sel_addr2_c  = addr2_q[c];
        sel_flits_c  = 32'(hermes_flits_available_i[c*HERMES_FLIT_SIZE +: HERMES_FLIT_SIZE]);
        sel_active_c = hermes_active_i[c];
      end
    end
  end

  // Read mux; unmapped and write-only addresses return 0
  always_comb begin
    rdata_c = '0;
    case (cfg_addr_i)
      A_STATUS:     rdata_c = {16'd0, 8'(hermes_active_i), 5'd0, br_local_busy_i,
                               fifo_empty_c, fifo_full_c};
      A_IRQ_STATUS: rdata_c = 32'(irq_status_c);
      A_IRQ_MASK:   rdata_c = 32'(mask_q);
      A_PENDING:    rdata_c = 32'(pending_q);
      A_CH_SEL:     rdata_c = 32'(sel_q);
      A_OP:         rdata_c = 32'(sel_op_c);
      A_SIZE:       rdata_c = sel_size_c;
      A_SIZE2:      rdata_c = sel_size2_c;
      A_ADDR:       rdata_c = sel_addr_c;
      A_ADDR2:      rdata_c = sel_addr2_c;
      A_FLITS:      rdata_c = sel_flits_c;
      A_SERVICE:    rdata_c = 32'(stage_q.service);
      A_KSVC:       rdata_c = 32'(stage_q.ksvc);
      A_TARGET:     rdata_c = 32'(stage_q.target);
      A_PRODUCER:   rdata_c = 32'(stage_q.producer);
      A_PAYLOAD:    rdata_c = stage_q.payload;
      A_TX_COUNT:   rdata_c = 32'(cnt_q);
      A_SVC_KSVC:   rdata_c = 32'(br_svc_data_i.ksvc);
      A_SVC_PROD:   rdata_c = {br_svc_data_i.seq_source, br_svc_data_i.producer};
      A_SVC_PAY:    rdata_c = br_svc_data_i.payload;
      default:      rdata_c = '0;
    endcase
  end

  // MMR registers, sticky status, start pulses, service pop and IRQ output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q          <= '0;
      mask_q         <= 7'h07;
      pending_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      tx_ovf_q       <= 1'b0;
      start_err_q    <= 1'b0;
      tx_to_q        <= 1'b0;
      stage_q        <= '0;
      hermes_start_o <= '0;
      br_svc_ack_o   <= 1'b0;
      irq_o          <= 1'b0;
      cfg_data_o     <= '0;
      for (int c = 0; c < int'(N_HERMES_CH); c++) begin
        op_q[c]    <= HERMES_OPERATION_SEND;
        size_q[c]  <= '0;
        size2_q[c] <= '0;
        addr_q[c]  <= '0;
        addr2_q[c] <= '0;
      end
    end else begin
      if (rd_c) cfg_data_o <= rdata_c;

      if (wr_c) begin
        case (cfg_addr_i)
          A_IRQ_MASK: mask_q           <= cfg_data_i[6:0];
          A_PENDING:  pending_q        <= cfg_data_i[0];
          A_CH_SEL:   if (cfg_data_i < 32'(N_HERMES_CH)) sel_q <= SEL_W'(cfg_data_i);
          A_SERVICE:  stage_q.service  <= cfg_data_i[1:0];
          A_KSVC:     stage_q.ksvc     <= cfg_data_i[7:0];
          A_TARGET:   stage_q.target   <= cfg_data_i[15:0];
          A_PRODUCER: stage_q.producer <= cfg_data_i[15:0];
          A_PAYLOAD:  stage_q.payload  <= cfg_data_i;
          default: ;
        endcase
      end

      for (int c = 0; c < int'(N_HERMES_CH); c++) begin
        if (wr_c && sel_q == SEL_W'(c)) begin
          case (cfg_addr_i)
            A_OP:    op_q[c]    <= hermes_op_t'(cfg_data_i[HERMES_OP_W-1:0]);
            A_SIZE:  size_q[c]  <= cfg_data_i;
            A_SIZE2: size2_q[c] <= cfg_data_i;
            A_ADDR:  addr_q[c]  <= cfg_data_i;
            A_ADDR2: addr2_q[c] <= cfg_data_i;
            default: ;
          endcase
        end
      end

      // Set events override a coincident clear
      tx_done_q   <= done_evt_c      | (tx_done_q   & ~clr_c[3]);
      tx_ovf_q    <= ovf_evt_c       | (tx_ovf_q    & ~clr_c[4]);
      start_err_q <= start_err_evt_c | (start_err_q & ~clr_c[5]);
      tx_to_q     <= timeout_evt_c   | (tx_to_q     & ~clr_c[6]);

      hermes_start_o <= '0;
      if (start_req_c && !sel_active_c) hermes_start_o <= N_HERMES_CH'(1) << sel_q;

      // A pop request seen while the pulse is high is dropped
      br_svc_ack_o <= svc_pop_c && !br_svc_ack_o;

      irq_o <= |(irq_status_c & mask_q);
    end
  end

  // FIFO storage; contents are don't-care once pointers reset
  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= stage_q;
  end

  // FIFO pointers/count and BrLite request FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      br_req_o  <= 1'b0;
      br_data_o <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok_c, pop_c})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase

      case (state_q)
        S_IDLE: begin
          if (!fifo_empty_c && !br_local_busy_i) begin
            state_q   <= S_REQ;
            br_req_o  <= 1'b1;
            br_data_o <= mem_q[rd_ptr_q];
          end
        end
        S_REQ: begin
          if (br_ack_i || wdt_expire_c) begin
            state_q  <= S_IDLE;
            br_req_o <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          br_req_o <= 1'b0;
        end
      endcase
    end
  end

  // Flatten per-channel registers onto the output buses
  for (genvar c = 0; c < int'(N_HERMES_CH); c++) begin : g_out
    assign hermes_operation_o[c*HERMES_OP_W +: HERMES_OP_W] = op_q[c];
    assign hermes_size_o[c*32 +: 32]      = size_q[c];
    assign hermes_size_2_o[c*32 +: 32]    = size2_q[c];
    assign hermes_address_o[c*32 +: 32]   = addr_q[c];
    assign hermes_address_2_o[c*32 +: 32] = addr2_q[c];
  end

endmodule

// File: tb/tb_dmni_ni_mc.sv
// Directed self-checking bench for dmni_ni_mc (N=2, DEPTH=4, watchdog 16).
`timescale 1ns/1ps
module tb_dmni_ni_mc;
  import dmni_ni_mc_pkg::*;

  localparam int unsigned FLIT  = 32;
  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WDT   = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 irq;
  logic                 cfg_en = 1'b0, cfg_we = 1'b0;
  logic [5:0]           cfg_addr = '0;
  logic [31:0]          cfg_wdata = '0, cfg_rdata;
  logic [NCH-1:0]       active = '0, rx_avail = '0;
  logic [NCH*FLIT-1:0]  flits = '0;
  logic [NCH-1:0]       start;
  logic [NCH-1:0]       op;
  logic [NCH*32-1:0]    size, size2, addr, addr2;
  logic                 svc_rx = 1'b0, svc_ack;
  brlite_svc_t          svc_data = '0;
  logic                 busy = 1'b0, req, ack = 1'b0;
  brlite_out_t          br_data;

  int n_total = 0;
  int n_bad   = 0;

  dmni_ni_mc #(
    .HERMES_FLIT_SIZE(FLIT), .N_HERMES_CH(NCH), .BR_TX_DEPTH(DEPTH), .BR_WDT_CYCLES(WDT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .irq_o(irq),
    .cfg_en_i(cfg_en), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_wdata), .cfg_data_o(cfg_rdata),
    .hermes_active_i(active), .hermes_rx_available_i(rx_avail),
    .hermes_flits_available_i(flits), .hermes_start_o(start),
    .hermes_operation_o(op), .hermes_size_o(size), .hermes_size_2_o(size2),
    .hermes_address_o(addr), .hermes_address_2_o(addr2),
    .br_svc_rx_i(svc_rx), .br_svc_ack_o(svc_ack), .br_svc_data_i(svc_data),
    .br_local_busy_i(busy), .br_req_o(req), .br_ack_i(ack), .br_data_o(br_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mmr_wr(input logic [5:0] a, input logic [31:0] d);
    cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc();
    cfg_en = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    cfg_en = 1'b1; cfg_we = 1'b0; cfg_addr = a;
    cyc();
    cfg_en = 1'b0;
    check_eq(tag, 96'(cfg_rdata), 96'(exp));
  endtask

  task automatic push_entry(input logic [7:0] ksvc, input logic [31:0] payload);
    mmr_wr(6'h11, 32'(ksvc));
    mmr_wr(6'h14, payload);
    mmr_wr(6'h15, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!req && n < 50) begin
      cyc();
      n++;
    end
    check_eq({tag, "_req"}, 96'(req), 96'd1);
  endtask

  // Wait for request, hold it two cycles, ack and confirm the drop
  task automatic serve(input string tag, input logic [31:0] exp_payload);
    wait_req(tag);
    cyc();
    cyc();
    check_eq({tag, "_held"}, 96'({req, br_data.payload}), 96'({1'b1, exp_payload}));
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    check_eq({tag, "_drop"}, 96'(req), 96'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    brlite_out_t exp_out;
    int n;

    // T1 reset
    cyc(); cyc();
    check_eq("rst_outs", 96'({irq, start, op, req, svc_ack, cfg_rdata}), 96'd0);
    check_eq("rst_buses", 96'(size | size2 | addr | addr2), 96'd0);
    check_eq("rst_brdata", 96'(br_data), 96'd0);
    rst = 1'b0;
    cyc();
    chk_rd("rst_mask", 6'h02, 32'h07);
    chk_rd("rst_status", 6'h00, 32'h2);
    mmr_wr(6'h3F, 32'hFFFF_FFFF);
    chk_rd("unmapped", 6'h3F, 32'h0);

    // T2 banking and start
    mmr_wr(6'h08, 32'd1);
    mmr_wr(6'h0B, 32'h40);
    check_eq("size_bank", 96'(size), 96'({32'h40, 32'h0}));
    mmr_wr(6'h0A, 32'd1);
    check_eq("op_bank", 96'(op), 96'(2'b10));
    mmr_wr(6'h09, 32'd1);
    check_eq("start_pulse", 96'(start), 96'(2'b10));
    cyc();
    check_eq("start_end", 96'(start), 96'd0);
    active = 2'b10;
    mmr_wr(6'h09, 32'd1);
    check_eq("start_busy", 96'(start), 96'd0);
    chk_rd("start_err", 6'h01, 32'h20);
    chk_rd("status_act", 6'h00, 32'h202);
    check_eq("irq_masked", 96'(irq), 96'd0);
    mmr_wr(6'h08, 32'd2);
    chk_rd("chsel_ign", 6'h08, 32'd1);
    flits = {32'h55, 32'h11};
    chk_rd("flits1", 6'h0F, 32'h55);
    chk_rd("size_rd1", 6'h0B, 32'h40);
    mmr_wr(6'h08, 32'd0);
    chk_rd("size_rd0", 6'h0B, 32'h0);
    chk_rd("flits0", 6'h0F, 32'h11);
    mmr_wr(6'h03, 32'h20);
    chk_rd("clr_err", 6'h01, 32'h0);
    active = '0;

    // T3 FIFO fill, overflow, drain in order
    busy = 1'b1;
    mmr_wr(6'h10, 32'd2);
    mmr_wr(6'h12, 32'h0123);
    mmr_wr(6'h13, 32'h0456);
    for (int i = 0; i < 5; i++) push_entry(8'(i), 32'hA000_0000 + 32'(i));
    chk_rd("cnt_full", 6'h16, 32'd4);
    chk_rd("ovf", 6'h01, 32'h10);
    chk_rd("status_full", 6'h00, 32'h5);
    check_eq("no_req_busy", 96'(req), 96'd0);
    busy = 1'b0;
    wait_req("first");
    exp_out = '{service: 2'd2, ksvc: 8'h00, target: 16'h0123, producer: 16'h0456,
                payload: 32'hA000_0000};
    check_eq("first_entry", 96'(br_data), 96'(exp_out));
    for (int i = 0; i < 4; i++) serve("t3", 32'hA000_0000 + 32'(i));
    chk_rd("cnt_empty", 6'h16, 32'd0);
    chk_rd("done_ovf", 6'h01, 32'h18);
    mmr_wr(6'h03, 32'h78);

    // T4 full + push + pop in the same cycle
    busy = 1'b1;
    for (int i = 0; i < 4; i++) push_entry(8'h20 + 8'(i), 32'hB000_0000 + 32'(i));
    mmr_wr(6'h14, 32'hB000_0004);
    chk_rd("t4_full", 6'h16, 32'd4);
    busy = 1'b0;
    wait_req("t4");
    cyc();
    check_eq("t4_head", 96'(br_data.payload), 96'h0B000_0000);
    ack = 1'b1;
    cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = 6'h15; cfg_wdata = 32'd1;
    cyc();
    ack = 1'b0; cfg_en = 1'b0; cfg_we = 1'b0;
    chk_rd("t4_cnt", 6'h16, 32'd4);
    chk_rd("t4_noovf", 6'h01, 32'h08);
    for (int i = 1; i < 5; i++) serve("t4", 32'hB000_0000 + 32'(i));
    chk_rd("t4_empty", 6'h16, 32'd0);
    mmr_wr(6'h03, 32'h78);

    // T5 IRQ latency, clear, clear vs set
    mmr_wr(6'h02, 32'h08);
    push_entry(8'h30, 32'hD000_0000);
    serve("t5a", 32'hD000_0000);
    check_eq("irq_lat0", 96'(irq), 96'd0);
    cyc();
    check_eq("irq_set", 96'(irq), 96'd1);
    mmr_wr(6'h03, 32'h08);
    cyc();
    check_eq("irq_clr", 96'(irq), 96'd0);
    push_entry(8'h31, 32'hD000_0001);
    wait_req("t5b");
    cyc();
    ack = 1'b1;
    cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = 6'h03; cfg_wdata = 32'h08;
    cyc();
    ack = 1'b0; cfg_en = 1'b0; cfg_we = 1'b0;
    chk_rd("set_wins", 6'h01, 32'h08);
    check_eq("irq_again", 96'(irq), 96'd1);
    mmr_wr(6'h02, 32'h00);
    cyc();
    check_eq("irq_mask0", 96'(irq), 96'd0);
    mmr_wr(6'h03, 32'h78);
    mmr_wr(6'h02, 32'h07);

    // Service FIFO front end and live IRQ bits
    svc_rx = 1'b1;
    rx_avail = 2'b01;
    svc_data = '{ksvc: 8'h5A, seq_source: 16'h0003, producer: 16'h0777, payload: 32'hCAFE_0001};
    chk_rd("svc_ksvc", 6'h18, 32'h5A);
    chk_rd("svc_prod", 6'h19, 32'h0003_0777);
    chk_rd("svc_pay", 6'h1A, 32'hCAFE_0001);
    mmr_wr(6'h04, 32'd1);
    chk_rd("irq_live", 6'h01, 32'h07);
    check_eq("irq_live_o", 96'(irq), 96'd1);
    mmr_wr(6'h1B, 32'd1);
    check_eq("svc_ack1", 96'(svc_ack), 96'd1);
    mmr_wr(6'h1B, 32'd1);
    check_eq("svc_rearm", 96'(svc_ack), 96'd0);
    mmr_wr(6'h1B, 32'd1);
    check_eq("svc_ack2", 96'(svc_ack), 96'd1);
    cyc();
    check_eq("svc_ack_end", 96'(svc_ack), 96'd0);
    mmr_wr(6'h04, 32'd0);
    svc_rx = 1'b0;
    rx_avail = '0;

`ifdef DMNI_BR_WDT_EN
    // T6 watchdog expiry, then the next entry is requested
    busy = 1'b1;
    push_entry(8'h40, 32'hC000_0000);
    push_entry(8'h41, 32'hC000_0001);
    busy = 1'b0;
    wait_req("t6");
    check_eq("t6_head", 96'(br_data.payload), 96'h0C000_0000);
    n = 0;
    while (req && n < 100) begin
      n++;
      cyc();
    end
    check_eq("wdt_len", 96'(n), 96'd16);
    chk_rd("wdt_flag", 6'h01, 32'h40);
    serve("t6b", 32'hC000_0001);
    chk_rd("t6_empty", 6'h16, 32'd0);
    mmr_wr(6'h03, 32'h78);
`else
    // Without the watchdog a request waits for ack indefinitely
    push_entry(8'h40, 32'hC000_0000);
    wait_req("t6");
    for (int i = 0; i < 40; i++) cyc();
    check_eq("no_wdt_hold", 96'({req, br_data.payload}), 96'({1'b1, 32'hC000_0000}));
    chk_rd("no_wdt_flag", 6'h01, 32'h00);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    n = 0;
    mmr_wr(6'h03, 32'h78);
`endif

    // Reset during REQ drops the request at once and empties the FIFO
    busy = 1'b1;
    push_entry(8'h50, 32'hE000_0000);
    push_entry(8'h51, 32'hE000_0001);
    busy = 1'b0;
    wait_req("rst_req");
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_drop", 96'(req), 96'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk_rd("rst_fifo", 6'h16, 32'd0);
    cyc(); cyc();
    check_eq("rst_no_req", 96'(req), 96'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
